// File: rtl/raifes_gpio_ctrl.sv
// raifes_gpio_ctrl: AHB-lite (HASTI) GPIO controller.
//   GPIO_WIDTH pins with per-bit direction, atomic SET/CLR, synchronised inputs.
//   Optional edge-triggered interrupts are built only when RAIFES_GPIO_IRQ_EN is defined;
//   without it, offsets 0x14-0x1C read 0, ignore writes, and irq is tied low.
// Bus handshake: a transfer is accepted in its address phase when it hits the window,
//   htrans[1] is set and hready is high. Accepted, well-formed transfers complete in the
//   next cycle (DATA, zero wait states). Malformed transfers get the two-cycle ERROR
//   response (ERR1 with hready low, then ERR2 with hready high). Nothing else stalls.
module raifes_gpio_ctrl #(
  parameter int          GPIO_WIDTH        = 32,
  parameter logic [31:0] BASE_ADDR         = 32'hC000_0000,
  parameter int          SYNC_STAGES       = 2,
  parameter int          HASTI_ADDR_WIDTH  = 32,
  parameter int          HASTI_BUS_WIDTH   = 32,
  parameter int          HASTI_SIZE_WIDTH  = 3,
  parameter int          HASTI_TRANS_WIDTH = 2,
  parameter int          HASTI_RESP_WIDTH  = 1,
  parameter int          HASTI_BURST_WIDTH = 3,
  parameter int          HASTI_PROT_WIDTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  output logic [GPIO_WIDTH-1:0]        gpio_d,
  output logic [GPIO_WIDTH-1:0]        gpio_en,
  input  logic [GPIO_WIDTH-1:0]        gpio_i,
  output logic                         irq,
  input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
  input  logic                         hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] hburst,
  input  logic                         hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
  output logic                         hready,
  output logic [HASTI_RESP_WIDTH-1:0]  hresp,
  output logic [1:0]                   dbg_state
);

  // Register word indices (haddr[4:2]).
  localparam logic [2:0] OFF_DATA_OUT = 3'd0;
  localparam logic [2:0] OFF_DIR      = 3'd1;
  localparam logic [2:0] OFF_DATA_IN  = 3'd2;
  localparam logic [2:0] OFF_SET      = 3'd3;
  localparam logic [2:0] OFF_CLR      = 3'd4;
  localparam logic [2:0] OFF_IRQ_EN   = 3'd5;
  localparam logic [2:0] OFF_IRQ_PEND = 3'd6;
  localparam logic [2:0] OFF_IRQ_EDGE = 3'd7;

  // Bits at or above GPIO_WIDTH are never stored and read back as 0.
  localparam logic [31:0] PIN_MASK = 32'((64'd1 << GPIO_WIDTH) - 64'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t state, state_nx;

  // Data-phase copies of the address-phase controls.
  logic [2:0] d_off;
  logic       d_write;
  logic [3:0] d_strb;

  logic        addr_sel;
  logic        addr_bad;
  logic [3:0]  strb_a;
  logic        wr_en;
  logic [31:0] wmask;
  logic [31:0] wbits;

  logic [31:0] data_out_q;
  logic [31:0] dir_q;
  logic [31:0] data_in;

  logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];

  // Control-only AHB inputs have no effect on this slave.
  logic unused_ok;
  assign unused_ok = ^{hburst, hmastlock, hprot, htrans[0]};

  assign addr_sel = (haddr[31:5] == BASE_ADDR[31:5]) && htrans[1] && hready;
  assign addr_bad = (hsize > 3'd2) ||
                    ((hsize == 3'd1) && haddr[0]) ||
                    ((hsize == 3'd2) && (haddr[1:0] != 2'b00));

  // Byte strobes from transfer size and the low address bits.
  always_comb begin
    strb_a = 4'b1111;
    case (hsize)
      3'd0:    strb_a = 4'b0001 << haddr[1:0];
      3'd1:    strb_a = haddr[1] ? 4'b1100 : 4'b0011;
      default: strb_a = 4'b1111;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next state and bus response; ERR1 always moves on, other states follow the address phase.
  always_comb begin
    state_nx = ST_IDLE;
    hready   = 1'b1;
    hresp    = '0;
    case (state)
      ST_ERR1: begin
        state_nx = ST_ERR2;
        hready   = 1'b0;
        hresp    = 1'b1;
      end
      default: begin
        if (state == ST_ERR2) hresp = 1'b1;
        if (addr_sel) state_nx = addr_bad ? ST_ERR1 : ST_DATA;
        else          state_nx = ST_IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // Capture the accepted address phase for use in the data phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_off   <= '0;
      d_write <= 1'b0;
      d_strb  <= '0;
    end else if (addr_sel && !addr_bad) begin
      d_off   <= haddr[4:2];
      d_write <= hwrite;
      d_strb  <= strb_a;
    end
  end

  assign wr_en = (state == ST_DATA) && d_write;
  assign wmask = {{8{d_strb[3]}}, {8{d_strb[2]}}, {8{d_strb[1]}}, {8{d_strb[0]}}};
  assign wbits = hwdata & wmask;

  // Output data and direction registers, committed at the end of the data phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= '0;
      dir_q      <= '0;
    end else if (wr_en) begin
      case (d_off)
        OFF_DATA_OUT: data_out_q <= ((data_out_q & ~wmask) | wbits) & PIN_MASK;
        OFF_SET:      data_out_q <= data_out_q | (wbits & PIN_MASK);
        OFF_CLR:      data_out_q <= data_out_q & ~wbits;
        OFF_DIR:      dir_q      <= ((dir_q & ~wmask) | wbits) & PIN_MASK;
        default: ;
      endcase
    end
  end

  assign gpio_d  = data_out_q[GPIO_WIDTH-1:0];
  assign gpio_en = dir_q[GPIO_WIDTH-1:0];

  // Input synchroniser chain; the last stage is the DATA_IN value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign data_in = 32'(sync_q[SYNC_STAGES-1]);

`ifdef RAIFES_GPIO_IRQ_EN
  // Only pins 0..15 have edge-select bits.
  localparam int          NEDGE     = (GPIO_WIDTH < 16) ? GPIO_WIDTH : 16;
  localparam logic [31:0] EDGE_MASK = {PIN_MASK[15:0], PIN_MASK[15:0]};

  logic [GPIO_WIDTH-1:0] in_prev;
  logic [GPIO_WIDTH-1:0] rise;
  logic [GPIO_WIDTH-1:0] fall;
  logic [31:0]           edge_ev;
  logic [31:0]           pend_clr;
  logic [31:0]           irq_en_q;
  logic [31:0]           pend_q;
  logic [31:0]           edge_sel_q;
  logic                  irq_q;

  assign rise     = sync_q[SYNC_STAGES-1] & ~in_prev;
  assign fall     = ~sync_q[SYNC_STAGES-1] & in_prev;
  assign pend_clr = (wr_en && (d_off == OFF_IRQ_PEND)) ? wbits : '0;

  // Edge events qualified by the per-pin rise/fall selects.
  always_comb begin
    edge_ev = '0;
    for (int i = 0; i < NEDGE; i++)
      edge_ev[i] = (rise[i] & edge_sel_q[i]) | (fall[i] & edge_sel_q[16+i]);
  end

  // Interrupt registers; a new edge event beats a W1C of the same pending bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_prev    <= '0;
      irq_en_q   <= '0;
      pend_q     <= '0;
      edge_sel_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      in_prev <= sync_q[SYNC_STAGES-1];
      pend_q  <= ((pend_q & ~pend_clr) | edge_ev) & PIN_MASK;
      irq_q   <= |(pend_q & irq_en_q);
      if (wr_en && (d_off == OFF_IRQ_EN))
        irq_en_q <= ((irq_en_q & ~wmask) | wbits) & PIN_MASK;
      if (wr_en && (d_off == OFF_IRQ_EDGE))
        edge_sel_q <= ((edge_sel_q & ~wmask) | wbits) & EDGE_MASK;
    end
  end

  assign irq = irq_q;

  // Read mux, valid only in the data phase.
  always_comb begin
    hrdata = '0;
    if (state == ST_DATA) begin
      case (d_off)
        OFF_DATA_OUT: hrdata = data_out_q;
        OFF_DIR:      hrdata = dir_q;
        OFF_DATA_IN:  hrdata = data_in;
        OFF_IRQ_EN:   hrdata = irq_en_q;
        OFF_IRQ_PEND: hrdata = pend_q;
        OFF_IRQ_EDGE: hrdata = edge_sel_q;
        default:      hrdata = '0;
      endcase
    end
  end
`else
  assign irq = 1'b0;

  // Read mux, valid only in the data phase; interrupt offsets read 0.
  always_comb begin
    hrdata = '0;
    if (state == ST_DATA) begin
      case (d_off)
        OFF_DATA_OUT: hrdata = data_out_q;
        OFF_DIR:      hrdata = dir_q;
        OFF_DATA_IN:  hrdata = data_in;
        default:      hrdata = '0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_raifes_gpio_ctrl.sv
// Directed, table-driven bench for raifes_gpio_ctrl (interrupt checks follow RAIFES_GPIO_IRQ_EN).
module tb_raifes_gpio_ctrl;

  localparam logic [31:0] BASE = 32'hC000_0000;
  localparam int          SYNC = 2;
`ifdef RAIFES_GPIO_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif

  // clock / reset / bus signals
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] gpio_d, gpio_en, gpio_i;
  logic        irq;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hmastlock;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic [31:0] hwdata, hrdata;
  logic        hready;
  logic [0:0]  hresp;
  logic [1:0]  dbg_state;

  raifes_gpio_ctrl #(.GPIO_WIDTH(32), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .gpio_d(gpio_d), .gpio_en(gpio_en), .gpio_i(gpio_i),
    .irq(irq), .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // scoreboard
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One isolated transfer: address phase, data phase, then bus idle.
  task automatic bus_xfer(input logic wr, input logic [4:0] off, input logic [2:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output logic rsp);
    @(negedge clk);
    haddr  = BASE | 32'(off);
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    @(posedge clk); #1;
    htrans = 2'b00;
    hwdata = wd;
    @(negedge clk);
    rd  = hrdata;
    rsp = hresp[0];
    @(posedge clk); #1;
  endtask

  typedef enum int { K_WR, K_RD, K_GD, K_GE } kind_t;
  typedef struct {
    kind_t       kind;
    logic [4:0]  off;
    logic [2:0]  sz;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(kind_t k, logic [4:0] o, logic [2:0] s, logic [31:0] w,
                              logic [31:0] e, string n);
    vec_t v;
    v.kind = k; v.off = o; v.sz = s; v.wdata = w; v.exp = e; v.name = n;
    return v;
  endfunction

  logic [31:0] rd;
  logic        rsp;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; gpio_i = '0; haddr = '0; hwrite = 1'b0; hsize = 3'd2;
    hburst = '0; hmastlock = 1'b0; hprot = '0; htrans = 2'b00; hwdata = '0;

    // directed vector table
    vecs.push_back(mk(K_WR, 5'h04, 3'd2, 32'hFFFF_0000, 32'h0, "dir_wr"));
    vecs.push_back(mk(K_WR, 5'h00, 3'd2, 32'h1234_5678, 32'h0, "dout_wr"));
    vecs.push_back(mk(K_WR, 5'h0C, 3'd2, 32'h0000_0001, 32'h0, "set_wr"));
    vecs.push_back(mk(K_WR, 5'h10, 3'd2, 32'h0000_0008, 32'h0, "clr_wr"));
    vecs.push_back(mk(K_GD, 5'h00, 3'd2, 32'h0,         32'h1234_5671, "gpio_d_setclr"));
    vecs.push_back(mk(K_GE, 5'h00, 3'd2, 32'h0,         32'hFFFF_0000, "gpio_en_dir"));
    vecs.push_back(mk(K_RD, 5'h00, 3'd2, 32'h0,         32'h1234_5671, "dout_rd"));
    vecs.push_back(mk(K_RD, 5'h04, 3'd2, 32'h0,         32'hFFFF_0000, "dir_rd"));
    vecs.push_back(mk(K_RD, 5'h0C, 3'd2, 32'h0,         32'h0, "set_rd0"));
    vecs.push_back(mk(K_RD, 5'h10, 3'd2, 32'h0,         32'h0, "clr_rd0"));
    vecs.push_back(mk(K_WR, 5'h00, 3'd2, 32'h0,         32'h0, "dout_zero"));
    vecs.push_back(mk(K_WR, 5'h01, 3'd0, 32'h0000_AB00, 32'h0, "byte1_wr"));
    vecs.push_back(mk(K_RD, 5'h00, 3'd2, 32'h0,         32'h0000_AB00, "byte1_rd"));
    vecs.push_back(mk(K_WR, 5'h02, 3'd1, 32'hBEEF_0000, 32'h0, "half_hi_wr"));
    vecs.push_back(mk(K_RD, 5'h00, 3'd2, 32'h0,         32'hBEEF_AB00, "half_hi_rd"));
    vecs.push_back(mk(K_WR, 5'h03, 3'd0, 32'h11FF_FFFF, 32'h0, "byte3_wr"));
    vecs.push_back(mk(K_RD, 5'h00, 3'd2, 32'h0,         32'h11EF_AB00, "byte3_rd"));
    vecs.push_back(mk(K_WR, 5'h08, 3'd2, 32'hFFFF_FFFF, 32'h0, "din_wr_ignored"));
    vecs.push_back(mk(K_RD, 5'h08, 3'd2, 32'h0,         32'h0, "din_rd0"));
    vecs.push_back(mk(K_WR, 5'h0C, 3'd0, 32'hFFFF_FFFF, 32'h0, "set_byte0"));
    vecs.push_back(mk(K_RD, 5'h00, 3'd2, 32'h0,         32'h11EF_ABFF, "set_byte0_rd"));
    vecs.push_back(mk(K_WR, 5'h12, 3'd1, 32'h00FF_FFFF, 32'h0, "clr_half_hi"));
    vecs.push_back(mk(K_RD, 5'h00, 3'd2, 32'h0,         32'h1100_ABFF, "clr_half_rd"));
    vecs.push_back(mk(K_WR, 5'h14, 3'd2, 32'h0000_000F, 32'h0, "irqen_wr"));
    vecs.push_back(mk(K_RD, 5'h14, 3'd2, 32'h0,         IRQ_BUILT ? 32'hF : 32'h0, "irqen_rd"));
    vecs.push_back(mk(K_WR, 5'h1C, 3'd2, 32'h0003_0001, 32'h0, "edge_wr"));
    vecs.push_back(mk(K_RD, 5'h1C, 3'd2, 32'h0,         IRQ_BUILT ? 32'h0003_0001 : 32'h0, "edge_rd"));
    vecs.push_back(mk(K_WR, 5'h14, 3'd2, 32'h0,         32'h0, "irqen_clr"));
    vecs.push_back(mk(K_WR, 5'h1C, 3'd2, 32'h0,         32'h0, "edge_clr"));
    vecs.push_back(mk(K_RD, 5'h18, 3'd2, 32'h0,         32'h0, "pend_rd0"));

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpio_d", gpio_d, 32'h0);
    check("rst_gpio_en", gpio_en, 32'h0);
    check("rst_hready", 32'(hready), 32'h1);
    check("rst_hresp", 32'(hresp), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // table loop
    foreach (vecs[i]) begin
      case (vecs[i].kind)
        K_WR: begin
          bus_xfer(1'b1, vecs[i].off, vecs[i].sz, vecs[i].wdata, rd, rsp);
          check({vecs[i].name, "_resp"}, 32'(rsp), 32'h0);
        end
        K_RD: begin
          exp_q.push_back(vecs[i].exp);
          bus_xfer(1'b0, vecs[i].off, vecs[i].sz, 32'h0, rd, rsp);
          check(vecs[i].name, rd, exp_q.pop_front());
        end
        K_GD: check(vecs[i].name, gpio_d, vecs[i].exp);
        default: check(vecs[i].name, gpio_en, vecs[i].exp);
      endcase
    end

    // back-to-back: write DATA_OUT then read it in the very next data phase
    @(negedge clk);
    haddr = BASE; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 32'hCAFE_F00D; hwrite = 1'b0;
    exp_q.push_back(32'hCAFE_F00D);
    @(posedge clk); #1;
    htrans = 2'b00;
    @(negedge clk);
    check("b2b_rd", hrdata, exp_q.pop_front());
    check("b2b_state", 32'(dbg_state), 32'd1);

    // input latency: continuous DATA_IN reads, pin change right after the first sample
    @(negedge clk);
    haddr = BASE | 32'h08; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    @(posedge clk);
    for (int k = 0; k <= SYNC; k++) begin
      @(negedge clk);
      check($sformatf("din_lat_%0d", k), hrdata, (k < SYNC) ? 32'h0 : 32'h5);
      if (k == 0) gpio_i = 32'h5;
    end
    htrans = 2'b00;
    @(posedge clk); #1;

    // error response: hsize=3 write to DATA_OUT must not commit
    @(negedge clk);
    haddr = BASE; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd3;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("err1_hready", 32'(hready), 32'h0);
    check("err1_hresp", 32'(hresp), 32'h1);
    check("err1_state", 32'(dbg_state), 32'd2);
    @(negedge clk);
    check("err2_hready", 32'(hready), 32'h1);
    check("err2_hresp", 32'(hresp), 32'h1);
    @(negedge clk);
    check("err_done_hresp", 32'(hresp), 32'h0);
    check("err_gpio_d", gpio_d, 32'hCAFE_F00D);
    // misaligned word read
    @(negedge clk);
    haddr = BASE | 32'h06; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b00;
    @(negedge clk);
    check("mis_hresp", 32'(hresp), 32'h1);
    check("mis_hrdata", hrdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    bus_xfer(1'b0, 5'h00, 3'd2, 32'h0, rd, rsp);
    check("err_dout_rd", rd, 32'hCAFE_F00D);

`ifdef RAIFES_GPIO_IRQ_EN
    // edge interrupt on pin 0
    gpio_i = 32'h0;
    repeat (5) @(posedge clk);
    bus_xfer(1'b1, 5'h18, 3'd2, 32'hFFFF_FFFF, rd, rsp);
    bus_xfer(1'b1, 5'h14, 3'd2, 32'h0000_0001, rd, rsp);
    bus_xfer(1'b1, 5'h1C, 3'd2, 32'h0000_0001, rd, rsp);
    check("irq_idle", 32'(irq), 32'h0);
    gpio_i = 32'h1;
    repeat (6) @(posedge clk);
    #1;
    check("irq_set", 32'(irq), 32'h1);
    bus_xfer(1'b0, 5'h18, 3'd2, 32'h0, rd, rsp);
    check("pend_set", rd, 32'h1);
    bus_xfer(1'b1, 5'h18, 3'd2, 32'h0000_0001, rd, rsp);
    @(posedge clk); #1;
    check("irq_w1c", 32'(irq), 32'h0);
    gpio_i = 32'h0;
    repeat (5) @(posedge clk);
    // rising edge lands on the W1C commit edge: pending must stay set
    @(negedge clk) gpio_i = 32'h1;
    @(negedge clk);
    haddr = BASE | 32'h18; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'h1;
    @(posedge clk); #1;
    bus_xfer(1'b0, 5'h18, 3'd2, 32'h0, rd, rsp);
    check("pend_race", rd, 32'h1);
    check("irq_race", 32'(irq), 32'h1);
`else
    gpio_i = 32'h1;
    repeat (6) @(posedge clk);
    #1;
    check("irq_tied", 32'(irq), 32'h0);
`endif

    // reset asserted during the data phase of a DATA_OUT write
    @(negedge clk);
    haddr = BASE; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'h5555_5555;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_gpio_d", gpio_d, 32'h0);
    check("rst_mid_gpio_en", gpio_en, 32'h0);
    check("rst_mid_hready", 32'(hready), 32'h1);
    check("rst_mid_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    bus_xfer(1'b0, 5'h00, 3'd2, 32'h0, rd, rsp);
    check("rst_no_commit", rd, 32'h0);
    check("rst_gpio_d_after", gpio_d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
